// File: rtl/interval_sequencer_pkg.sv
// rtl/interval_sequencer_pkg.sv - shared types and defaults for the interval sequencer
package interval_sequencer_pkg;

  localparam int SEQ_N_STEPS = 8;
  localparam int SEQ_IDX_W   = 3;
  localparam int SEQ_VAL_W   = 9;

  // A zero-length interval terminates the sequence instead of being loaded
  localparam logic [SEQ_VAL_W-1:0] END_MARKER = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/dffr.sv
// rtl/dffr.sv - register with synchronous active-high clear
module dffr #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear to zero on reset, otherwise follow d every cycle
  always_ff @(posedge clock) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/dffre.sv
// rtl/dffre.sv - register with synchronous active-high clear and load enable
module dffre #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear to zero on reset, otherwise capture d only when enabled
  always_ff @(posedge clock) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/interval_table.sv
// rtl/interval_table.sv - interval storage with sync write, comb read, sync clear
module interval_table
  import interval_sequencer_pkg::*;
#(
  parameter int N_STEPS = SEQ_N_STEPS,
  parameter int IDX_W   = SEQ_IDX_W,
  parameter int VAL_W   = SEQ_VAL_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [VAL_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [VAL_W-1:0] rd_data
);

  logic [VAL_W-1:0] mem [N_STEPS];

  // Whole table clears on reset; writes land at the edge, so a same-cycle read sees the old value
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_STEPS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/interval_sequencer.sv
// rtl/interval_sequencer.sv - steps a countdown timer through a programmable interval table
module interval_sequencer
  import interval_sequencer_pkg::*;
#(
  parameter int N_STEPS = SEQ_N_STEPS,
  parameter int IDX_W   = SEQ_IDX_W,
  parameter int VAL_W   = SEQ_VAL_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [VAL_W-1:0] wr_data,
  input  logic             tmr_expired,
  output logic             tmr_load,
  output logic [VAL_W-1:0] tmr_value,
  output logic             tmr_en,
  output logic [IDX_W-1:0] step_idx,
  output logic             step_pulse,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STEPS - 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             idx_en;
  logic [VAL_W-1:0] cur_val;
  logic             at_end;

  assign state   = state_t'(state_q);
  assign state_d = state_next;
  assign at_end  = (cur_val == VAL_W'(END_MARKER));

  interval_table #(
    .N_STEPS (N_STEPS),
    .IDX_W   (IDX_W),
    .VAL_W   (VAL_W)
  ) u_table (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_q),
    .rd_data (cur_val)
  );

  // State register
  dffr #(.W(2)) u_state_reg (
    .clock (clock),
    .reset (reset),
    .d     (state_d),
    .q     (state_q)
  );

  // Step index register, only written on start, advance, wrap or stop
  dffre #(.W(IDX_W)) u_idx_reg (
    .clock (clock),
    .reset (reset),
    .en    (idx_en),
    .d     (idx_d),
    .q     (idx_q)
  );

  // Next state and step index; stop overrides everything and forces index 0
  always_comb begin
    state_next = state;
    idx_en     = 1'b0;
    idx_d      = idx_q;
    if (stop) begin
      state_next = ST_IDLE;
      idx_en     = 1'b1;
      idx_d      = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state_next = ST_LOAD;
            idx_en     = 1'b1;
            idx_d      = '0;
          end
        end
        ST_LOAD: begin
          state_next = at_end ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (tmr_expired) begin
            if (idx_q != LAST_IDX) begin
              state_next = ST_LOAD;
              idx_en     = 1'b1;
              idx_d      = idx_q + IDX_W'(1);
            end else if (loop_en) begin
              state_next = ST_LOAD;
              idx_en     = 1'b1;
              idx_d      = '0;
            end else begin
              state_next = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Moore output decode; tick reaches tmr_en only while running
  always_comb begin
    tmr_load   = 1'b0;
    tmr_value  = '0;
    tmr_en     = 1'b0;
    step_pulse = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_LOAD: begin
        busy = 1'b1;
        if (!at_end) begin
          tmr_load   = 1'b1;
          step_pulse = 1'b1;
          tmr_value  = cur_val;
        end
      end
      ST_RUN: begin
        busy   = 1'b1;
        tmr_en = tick;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign step_idx = idx_q;

endmodule

// File: tb/tb_interval_sequencer.sv
// tb/tb_interval_sequencer.sv - directed self-checking bench for interval_sequencer
module tb_interval_sequencer;

  localparam int IDX_W = 3;
  localparam int VAL_W = 9;

  logic             clock;
  logic             reset;
  logic             tick;
  logic             start;
  logic             stop;
  logic             loop_en;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [VAL_W-1:0] wr_data;
  logic             tmr_expired;
  logic             tmr_load;
  logic [VAL_W-1:0] tmr_value;
  logic             tmr_en;
  logic [IDX_W-1:0] step_idx;
  logic             step_pulse;
  logic             busy;
  logic             done;

  int n_cmp;
  int n_bad;

  logic [VAL_W-1:0] tmr_cnt;

  interval_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .tmr_expired (tmr_expired),
    .tmr_load    (tmr_load),
    .tmr_value   (tmr_value),
    .tmr_en      (tmr_en),
    .step_idx    (step_idx),
    .step_pulse  (step_pulse),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External countdown timer: load beats enable, expiry pulse follows the v-th enabled tick
  always @(posedge clock) begin
    if (reset) begin
      tmr_cnt     <= '0;
      tmr_expired <= 1'b0;
    end else begin
      tmr_expired <= 1'b0;
      if (tmr_load) begin
        tmr_cnt <= tmr_value;
      end else if (tmr_en && tmr_cnt != 0) begin
        tmr_cnt <= tmr_cnt - 1'b1;
        if (tmr_cnt == 1) tmr_expired <= 1'b1;
      end
    end
  end

  task automatic write_entry(input logic [IDX_W-1:0] a, input logic [VAL_W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clock); #1;
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    n_cmp++;
    if ({tmr_load, tmr_value, tmr_en, step_idx, step_pulse, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want all zero",
               {tmr_load, tmr_value, tmr_en, step_idx, step_pulse, busy, done});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic test_sequence();
    int loads, done_cnt, done_cyc, en_first;
    int load_cyc[4];
    logic [VAL_W-1:0] load_val[4];
    logic seen_exp;
    logic [IDX_W-1:0] done_idx;
    loads = 0; done_cnt = 0; done_cyc = -1; en_first = 0; seen_exp = 1'b0; done_idx = '0;
    write_entry(3'd0, 9'd5);
    write_entry(3'd1, 9'd3);
    write_entry(3'd2, 9'd0);
    for (int c = 0; c < 30; c++) begin
      start = (c == 0);
      tick  = 1'b1;
      @(negedge clock);
      if (tmr_load) begin
        if (loads < 4) begin
          load_cyc[loads] = c;
          load_val[loads] = tmr_value;
        end
        loads++;
      end
      if (tmr_expired) seen_exp = 1'b1;
      if (tmr_en && !seen_exp) en_first++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
        done_idx = step_idx;
      end
      @(posedge clock); #1;
    end
    start = 1'b0; tick = 1'b0;
    n_cmp++;
    if (loads !== 2) begin n_bad++; $display("FAIL seq_load_count: got %0d want 2", loads); end
    n_cmp++;
    if (loads >= 2 && (load_cyc[0] !== 1 || load_cyc[1] !== 8)) begin
      n_bad++; $display("FAIL seq_load_cycles: got %0d,%0d want 1,8", load_cyc[0], load_cyc[1]);
    end
    n_cmp++;
    if (loads >= 2 && (load_val[0] !== 9'd5 || load_val[1] !== 9'd3)) begin
      n_bad++; $display("FAIL seq_load_values: got %0d,%0d want 5,3", load_val[0], load_val[1]);
    end
    n_cmp++;
    if (en_first !== 5) begin n_bad++; $display("FAIL seq_ticks_first: got %0d want 5", en_first); end
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== 14) begin
      n_bad++; $display("FAIL seq_done: got count %0d cycle %0d want 1 at 14", done_cnt, done_cyc);
    end
    n_cmp++;
    if (done_idx !== 3'd2) begin n_bad++; $display("FAIL seq_done_idx: got %0d want 2", done_idx); end
  endtask

  task automatic test_loop();
    int loads, wrap_cyc, done_cyc, busy_after;
    logic [IDX_W-1:0] wrap_idx;
    loads = 0; wrap_cyc = -1; done_cyc = -1; busy_after = -1; wrap_idx = '1;
    for (int i = 0; i < 8; i++) write_entry(3'(i), 9'd2);
    loop_en = 1'b1;
    for (int c = 0; c < 80; c++) begin
      start = (c == 0);
      tick  = 1'b1;
      @(negedge clock);
      if (tmr_load) begin
        if (loads == 8) begin
          wrap_cyc = c;
          wrap_idx = step_idx;
        end
        if (loads >= 8 && step_idx == 3'd7) loop_en = 1'b0;
        loads++;
      end
      if (done) done_cyc = c;
      if (c == 66) busy_after = int'(busy);
      @(posedge clock); #1;
    end
    start = 1'b0; tick = 1'b0; loop_en = 1'b0;
    n_cmp++;
    if (wrap_cyc !== 33 || wrap_idx !== 3'd0) begin
      n_bad++; $display("FAIL loop_wrap: got cycle %0d idx %0d want 33 idx 0", wrap_cyc, wrap_idx);
    end
    n_cmp++;
    if (loads !== 16) begin n_bad++; $display("FAIL loop_load_count: got %0d want 16", loads); end
    n_cmp++;
    if (done_cyc !== 65) begin n_bad++; $display("FAIL loop_done_cycle: got %0d want 65", done_cyc); end
    n_cmp++;
    if (busy_after !== 0) begin n_bad++; $display("FAIL loop_busy_after: got %0d want 0", busy_after); end
  endtask

  task automatic test_empty_table();
    int load_seen, done_cyc, busy_load;
    load_seen = 0; done_cyc = -1; busy_load = -1;
    write_entry(3'd0, 9'd0);
    for (int c = 0; c < 6; c++) begin
      start = (c == 0);
      @(negedge clock);
      if (tmr_load || step_pulse) load_seen++;
      if (c == 1) busy_load = int'(busy);
      if (done) done_cyc = c;
      @(posedge clock); #1;
    end
    start = 1'b0;
    n_cmp++;
    if (load_seen !== 0) begin n_bad++; $display("FAIL empty_no_load: got %0d want 0", load_seen); end
    n_cmp++;
    if (busy_load !== 1) begin n_bad++; $display("FAIL empty_busy_load: got %0d want 1", busy_load); end
    n_cmp++;
    if (done_cyc !== 2) begin n_bad++; $display("FAIL empty_done_cycle: got %0d want 2", done_cyc); end
  endtask

  task automatic test_stop();
    int idx_before, bad_after, done_seen;
    idx_before = -1; bad_after = 0; done_seen = 0;
    write_entry(3'd0, 9'd2);
    write_entry(3'd1, 9'd5);
    for (int c = 0; c < 13; c++) begin
      start = (c == 0) || (c == 7);
      stop  = (c == 7);
      tick  = 1'b1;
      @(negedge clock);
      if (c == 7) idx_before = int'(step_idx);
      if (c >= 8 && (busy || step_idx != 0 || tmr_load)) bad_after++;
      if (done) done_seen++;
      @(posedge clock); #1;
    end
    start = 1'b0; stop = 1'b0; tick = 1'b0;
    n_cmp++;
    if (idx_before !== 1) begin n_bad++; $display("FAIL stop_mid_idx: got %0d want 1", idx_before); end
    n_cmp++;
    if (bad_after !== 0) begin n_bad++; $display("FAIL stop_idle_after: got %0d bad cycles want 0", bad_after); end
    n_cmp++;
    if (done_seen !== 0) begin n_bad++; $display("FAIL stop_no_done: got %0d want 0", done_seen); end
  endtask

  task automatic test_slow_tick();
    int en_before, viol, done_cyc, loads;
    logic seen_exp;
    en_before = 0; viol = 0; done_cyc = -1; loads = 0; seen_exp = 1'b0;
    write_entry(3'd0, 9'd3);
    write_entry(3'd1, 9'd0);
    for (int c = 0; c < 20; c++) begin
      start = (c == 0);
      tick  = ((c % 4) == 1);
      @(negedge clock);
      if (tmr_load) loads++;
      if (tmr_expired) seen_exp = 1'b1;
      if (tmr_en && !seen_exp) en_before++;
      if (tmr_en && (!busy || tmr_load)) viol++;
      if (done) done_cyc = c;
      @(posedge clock); #1;
    end
    start = 1'b0; tick = 1'b0;
    n_cmp++;
    if (en_before !== 3) begin n_bad++; $display("FAIL slow_tick_count: got %0d want 3", en_before); end
    n_cmp++;
    if (viol !== 0) begin n_bad++; $display("FAIL slow_tick_en_outside_run: got %0d want 0", viol); end
    n_cmp++;
    if (done_cyc !== 16 || loads !== 1) begin
      n_bad++; $display("FAIL slow_tick_done: got cycle %0d loads %0d want 16 loads 1", done_cyc, loads);
    end
  endtask

  task automatic test_reset_mid_run();
    int loads_after, done_cyc;
    logic [VAL_W+IDX_W+4:0] outs;
    loads_after = 0; done_cyc = -1; outs = '1;
    write_entry(3'd0, 9'd4);
    for (int c = 0; c < 10; c++) begin
      start = (c == 0) || (c == 5);
      reset = (c == 3);
      tick  = 1'b1;
      @(negedge clock);
      if (c == 4) outs = {tmr_load, tmr_value, tmr_en, step_idx, step_pulse, busy, done};
      if (c >= 4 && tmr_load) loads_after++;
      if (done) done_cyc = c;
      @(posedge clock); #1;
    end
    start = 1'b0; reset = 1'b0; tick = 1'b0;
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL rst_mid_outputs: got %b want all zero", outs); end
    n_cmp++;
    if (loads_after !== 0) begin n_bad++; $display("FAIL rst_mid_table_clear: got %0d loads want 0", loads_after); end
    n_cmp++;
    if (done_cyc !== 7) begin n_bad++; $display("FAIL rst_mid_done: got %0d want 7", done_cyc); end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    tick    = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    @(posedge clock); #1;
    test_reset();
    test_sequence();
    test_loop();
    test_empty_table();
    test_stop();
    test_slow_tick();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
